// File: rtl/nibble_serial_add16_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nibble_serial_add16_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int DEFAULT_NIBBLES = 4;

  // Binary-encoded controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add16_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
// Latency: none (wiring only).
// Backpressure: none; start is only honoured while the adder is not busy.
interface nibble_serial_add16_if
  import nibble_serial_add16_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  // Requester side: issues operands, observes the result
  modport master (
    output start, in1, in2, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  // Adder side: consumes operands, produces the result
  modport slave (
    input  start, in1, in2, carry_in,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/nibble_serial_add16_parallel_adder.sv
// 4-bit combinational ripple-carry adder, shared by every nibble position.
// Latency: combinational.
// Backpressure: not applicable.
module parallel_adder
  import nibble_serial_add16_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out,
  input  logic [NIBBLE_W-1:0] in1,
  input  logic [NIBBLE_W-1:0] in2,
  input  logic                carry_in
);

  // Ripple the carry bit by bit through a chain of full adders
  always_comb begin
    logic c;
    c   = carry_in;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = in1[i] ^ in2[i] ^ c;
      c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
    end
    carry_out = c;
  end

endmodule

// File: rtl/nibble_serial_add16.sv
// Serial adder: one nibble per cycle through a single shared 4-bit adder.
// Latency: done pulses NIBBLES cycles after the accepting edge; one add per NIBBLES+2 cycles.
// Backpressure: start is ignored while busy; no queueing of requests.
module nibble_serial_add16
  import nibble_serial_add16_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                 clk,
  input  logic                 reset,
  nibble_serial_add16_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int POS_W = $clog2(W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [POS_W-1:0]    nib_lsb;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_carry;

  // Select the current nibble of each latched operand by index (no shifting)
  always_comb begin
    nib_lsb = POS_W'(idx_q) * POS_W'(NIBBLE_W);
    nib_a   = a_q[nib_lsb +: NIBBLE_W];
    nib_b   = b_q[nib_lsb +: NIBBLE_W];
  end

  parallel_adder u_adder (
    .sum       (nib_sum),
    .carry_out (nib_carry),
    .in1       (nib_a),
    .in2       (nib_b),
    .carry_in  (carry_q)
  );

  // Next-state and datapath updates; everything holds unless the state says otherwise
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          carry_d = bus.carry_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Only the addressed nibble changes, so partial results stay visible
        sum_d[nib_lsb +: NIBBLE_W] = nib_sum;
        carry_d = nib_carry;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = nib_carry;
          // Signed overflow: like-signed operands yielding a result of the other sign
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_sum[NIBBLE_W-1] != a_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed bench for the nibble-serial adder with hand-computed expected results.
// Latency: checks done arrives in the 5th cycle after the accepting edge.
// Backpressure: checks that start while busy is dropped.
module tb_nibble_serial_add16;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  nibble_serial_add16_if bus ();

  nibble_serial_add16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request at a negedge, scramble inputs after acceptance, wait for done.
  // lat = number of the cycle after the accepting edge in which done was seen (20 = timeout).
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in1      = a;
    bus.in2      = b;
    bus.carry_in = ci;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in1      = 16'($urandom);
    bus.in2      = 16'($urandom);
    bus.carry_in = 1'($urandom);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (bus.sum !== 16'h0000) begin
      miscompares++; $display("FAIL reset_sum: got %h, expected 0000", bus.sum);
    end
    vectors++;
    if ({bus.carry_out, bus.overflow, bus.busy, bus.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got cout/ovf/busy/done=%b, expected 0000",
               {bus.carry_out, bus.overflow, bus.busy, bus.done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    do_add(16'h1234, 16'h4321, 1'b0, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++; $display("FAIL basic_latency: got %0d, expected 5", lat);
    end
    vectors++;
    if ({bus.sum, bus.carry_out, bus.overflow, bus.busy} !== {16'h5555, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_result: got sum=%h cout=%b ovf=%b busy=%b, expected 5555 0 0 1",
               bus.sum, bus.carry_out, bus.overflow, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      miscompares++; $display("FAIL basic_done_pulse: got done/busy=%b, expected 00", {bus.done, bus.busy});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.sum !== 16'h5555) begin
      miscompares++; $display("FAIL idle_hold: got %h, expected 5555", bus.sum);
    end
  endtask

  task automatic test_carry_overflow();
    logic [15:0] ta [5];
    logic [15:0] tb [5];
    logic        tci[5];
    logic [15:0] esum[5];
    logic        ecout[5];
    logic        eovf[5];
    int lat;
    ta = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
    tb = '{16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
    tci = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    esum = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'hFFFE};
    ecout = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    eovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_add(ta[i], tb[i], tci[i], lat);
      vectors++;
      if ({lat == 5, bus.sum, bus.carry_out, bus.overflow} !== {1'b1, esum[i], ecout[i], eovf[i]}) begin
        miscompares++;
        $display("FAIL carry_ovf[%0d]: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=5 sum=%h cout=%b ovf=%b",
                 i, lat, bus.sum, bus.carry_out, bus.overflow, esum[i], ecout[i], eovf[i]);
      end
    end
  endtask

  // Preceding test leaves sum=FFFE: partial result shows untouched upper nibbles.
  task automatic test_ignore_restart();
    int lat;
    int extra;
    @(negedge clk);
    bus.start = 1'b1; bus.in1 = 16'h1111; bus.in2 = 16'h1111; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    vectors++;
    if (bus.sum !== 16'hFFFE) begin
      miscompares++; $display("FAIL partial_cycle1: got %h, expected FFFE", bus.sum);
    end
    @(negedge clk);
    lat = 2;
    vectors++;
    if (bus.sum !== 16'hFFF2) begin
      miscompares++; $display("FAIL partial_cycle2: got %h, expected FFF2", bus.sum);
    end
    bus.start = 1'b1; bus.in1 = 16'h0001; bus.in2 = 16'h0001;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 4) bus.start = 1'b0;
    end
    vectors++;
    if ({lat == 5, bus.sum} !== {1'b1, 16'h2222}) begin
      miscompares++; $display("FAIL restart_ignored: got lat=%0d sum=%h, expected lat=5 sum=2222", lat, bus.sum);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    vectors++;
    if ({extra, bus.busy, bus.sum} !== {32'd0, 1'b0, 16'h2222}) begin
      miscompares++;
      $display("FAIL restart_dropped: got extra_done=%0d busy=%b sum=%h, expected 0 0 2222", extra, bus.busy, bus.sum);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.in1 = 16'hAAAA; bus.in2 = 16'h5555; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.sum !== 16'h22FF) begin
      miscompares++; $display("FAIL abort_partial: got %h, expected 22FF", bus.sum);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.sum, bus.carry_out, bus.overflow, bus.busy, bus.done} !== 20'h0) begin
      miscompares++;
      $display("FAIL abort_clear: got sum=%h cout=%b ovf=%b busy=%b done=%b, expected all 0",
               bus.sum, bus.carry_out, bus.overflow, bus.busy, bus.done);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
    end
    do_add(16'h0F0F, 16'h00F1, 1'b0, lat);
    vectors++;
    if ({lat == 5, bus.sum, bus.carry_out, bus.overflow} !== {1'b1, 16'h1000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL after_reset: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=5 sum=1000 0 0",
               lat, bus.sum, bus.carry_out, bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] na[2];
    logic [15:0] nb[2];
    logic [15:0] ns[2];
    int lat;
    int gap;
    na = '{16'h0101, 16'h9000};
    nb = '{16'h0202, 16'h9000};
    ns = '{16'h0303, 16'h2000};
    do_add(16'h0000, 16'h0000, 1'b0, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++; $display("FAIL b2b_first: got lat=%0d, expected 5", lat);
    end
    for (int i = 0; i < 2; i++) begin
      // Raised while done is high, held through the first idle cycle
      bus.start = 1'b1; bus.in1 = na[i]; bus.in2 = nb[i]; bus.carry_in = 1'b0;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (gap == 2) begin
          bus.start = 1'b0; bus.in1 = 16'hDEAD; bus.in2 = 16'hBEEF; bus.carry_in = 1'b1;
        end
      end while (!bus.done && gap < 20);
      vectors++;
      if ({gap, bus.sum} !== {32'd6, ns[i]}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got gap=%0d sum=%h, expected gap=6 sum=%h", i, gap, bus.sum, ns[i]);
      end
    end
    vectors++;
    if ({bus.carry_out, bus.overflow} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_flags: got cout/ovf=%b, expected 11", {bus.carry_out, bus.overflow});
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in1      = '0;
    bus.in2      = '0;
    bus.carry_in = 1'b0;
    test_reset();
    test_basic();
    test_carry_overflow();
    test_ignore_restart();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; data width W = 4*NIBBLES (16 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 in1  input  W  operand A; sampled on the accepting edge.
REQ-006 in2  input  W  operand B; sampled on the accepting edge.
REQ-007 carry_in  input  1  carry into nibble 0; sampled on the accepting edge.
REQ-008 busy  output  1  high while state is ADD or DONE.
REQ-009 done  output  1  single-cycle pulse: sum, carry_out and overflow are valid.
REQ-010 sum  output  W  registered result.
REQ-011 carry_out  output  1  registered carry out of bit W-1.
REQ-012 overflow  output  1  registered signed-overflow flag.

Function
REQ-013 FSM states: IDLE, ADD, DONE; the encoding is binary.
REQ-014 IDLE with start=1 at an edge: latch in1, in2 and carry_in; set the carry register to carry_in; set the nibble index to 0; go to ADD.
REQ-015 IDLE with start=0: hold state and outputs.
REQ-016 ADD, every edge: add nibble[idx] of A and nibble[idx] of B with the carry register; write the 4-bit result into sum[4*idx+3:4*idx]; load the nibble carry into the carry register; increment idx.
REQ-017 ADD when idx = NIBBLES-1: after the write, go to DONE; carry_out gets the final nibble carry; overflow = (A[W-1]==B[W-1]) && (new sum[W-1]!=A[W-1]).
REQ-018 DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
REQ-019 Latency: start is accepted at edge k; done is high in the cycle after edge k+NIBBLES (5th cycle after start at default); throughput is one addition per NIBBLES+2 cycles.
REQ-020 start while in ADD or DONE is ignored; no queueing; latched operands stay unchanged.
REQ-021 in1/in2/carry_in changing after the accepting edge have no effect on the current result.
REQ-022 sum, carry_out and overflow hold their last values in IDLE until the next accepted start.
REQ-023 While ADD is active, sum shows partial results: nibbles not yet written keep their previous values.
REQ-024 Wrap-around: the sum is modulo 2^W; the carry beyond bit W-1 appears only on carry_out.
REQ-025 The nibble index is wide enough for NIBBLES-1 and never wraps inside one operation.

Reset
REQ-026 reset=1 forces immediately, with no clock: state IDLE, idx 0, carry register 0, latched operands 0, sum 0, carry_out 0, overflow 0, done 0, busy 0.
REQ-027 reset during ADD or DONE aborts the operation; no done pulse is produced; the next start after reset deasserts begins a fresh operation.

Structure
REQ-028 The shared package/header holds the state encodings (IDLE=0, ADD=1, DONE=2), NIBBLE_W=4, and the default NIBBLES.
REQ-029 Exactly one 4-bit combinational ripple adder sub-module, parallel_adder (ports sum, carry_out, in1, in2, carry_in), is instantiated and reused for every nibble; no other arithmetic on data bits.
REQ-030 Nibble selection uses a mux driven by idx; there is no shift register of the operands.

Verification
REQ-031 in1=0x1234, in2=0x4321, carry_in=0 -> sum=0x5555, carry_out=0, overflow=0, done in 5th cycle after start.
REQ-032 0xFFFF + 0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0; 0xFFFF + 0x0000, carry_in=1 -> same response.
REQ-033 0x7FFF + 0x0001 -> sum=0x8000, carry_out=0, overflow=1; 0x8000 + 0x8000 -> sum=0x0000, carry_out=1, overflow=1.
REQ-034 start re-pulsed with 0x0001+0x0001 two cycles into 0x1111+0x1111 -> single done, sum=0x2222; second request is dropped.
REQ-035 reset asserted mid-cycle at idx=2 of 0xAAAA+0x5555 -> all outputs 0 at once, no done; then 0x0F0F+0x00F1 -> sum=0x1000.
REQ-036 Back-to-back: a start on the first IDLE cycle after done is accepted; done pulses are exactly NIBBLES+2 cycles apart.
